cla_alu_pipe: RTL and testbench

CLA_ALU_PIPE -- requirements
Module: cla_alu_pipe

---
 rtl/alu_pkg.sv | 32 +++
 rtl/cla_group4.sv | 25 ++
 rtl/cla_alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_cla_alu_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead ALU.
//   OP_* : 3-bit op codes; op[2] inverts b and supplies the carry-in,
//          op[1:0] selects AND / OR / sum / less.
//   GROUP: bits per lookahead group.
//   gp4  : group generate/propagate from four per-bit g/p terms.
package alu_pkg;

  localparam int GROUP = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_OR   = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_LESS = 2'b11
  } sel_e;

  // Returns {G, P} for one 4-bit group.
  function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
    logic grp_g;
    logic grp_p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    return {grp_g, grp_p};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group, purely combinational.
//   g, p    : per-bit generate / propagate
//   cin     : carry into bit 0 of the group
//   c_inner : carries into bits 1..3 (flattened sum-of-products, no ripple)
//   g_grp   : group generate
//   p_grp   : group propagate
module cla_group4
  import alu_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [2:0] c_inner,
  output logic       g_grp,
  output logic       p_grp
);

  assign c_inner[0] = g[0] | (p[0] & cin);
  assign c_inner[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c_inner[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);

  assign {g_grp, p_grp} = gp4(g, p);

endmodule

// File: rtl/cla_alu_pipe.sv
// Two-stage pipelined ALU with carry-lookahead adder and valid/ready flow.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for a, b, op
//   a, b [WIDTH]        : two's complement operands
//   op [3]              : op[2] inverts b and is the carry-in; op[1:0] selects
//                         AND / OR / sum / signed less-than
//   out_valid/out_ready : output handshake
//   result [WIDTH]      : selected result
//   zero, overflow, cout: result==0, signed overflow, carry out of the MSB
module cla_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam int NGRP = WIDTH / GROUP;

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] bx_p1_q, bx_p1_d;
  logic [WIDTH-1:0] g_p1_q, g_p1_d;
  logic [WIDTH-1:0] p_p1_q, p_p1_d;
  logic [2:0]       op_p1_q, op_p1_d;
  logic [NGRP-1:0]  gg_p1_q, gg_p1_d;
  logic [NGRP-1:0]  gp_p1_q, gp_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] result_p2_q, result_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             ovf_p2_q, ovf_p2_d;
  logic             cout_p2_q, cout_p2_d;

  logic             s1_adv;
  logic             in_fire;

  assign s1_adv   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // ---- Stage 1: operand conditioning, per-bit g/p, per-group G/P ----
  always_comb begin
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    bx   = op[2] ? ~b : b;
    g_in = a & bx;
    p_in = a | bx;

    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    a_p1_d   = a_p1_q;
    bx_p1_d  = bx_p1_q;
    g_p1_d   = g_p1_q;
    p_p1_d   = p_p1_q;
    op_p1_d  = op_p1_q;
    gg_p1_d  = gg_p1_q;
    gp_p1_d  = gp_p1_q;
    if (in_fire) begin
      a_p1_d  = a;
      bx_p1_d = bx;
      g_p1_d  = g_in;
      p_p1_d  = p_in;
      op_p1_d = op;
      for (int k = 0; k < NGRP; k++) begin
        {gg_p1_d[k], gp_p1_d[k]} = gp4(g_in[GROUP*k +: 4], p_in[GROUP*k +: 4]);
      end
    end
  end

  // ---- Stage 2: lookahead carries, sum, result select, flags ----
  logic       grp_c [NGRP+1];
  logic [2:0] inner_c [NGRP];
  // G/P registered in stage 1 drive the group chain; the instance copies
  // are recomputed from the same g/p and are not needed.
  logic       grp_g_unused [NGRP];
  logic       grp_p_unused [NGRP];

  assign grp_c[0] = op_p1_q[2];

  for (genvar k = 0; k < NGRP; k++) begin : g_cla
    cla_group4 u_grp (
      .g       (g_p1_q[GROUP*k +: 4]),
      .p       (p_p1_q[GROUP*k +: 4]),
      .cin     (grp_c[k]),
      .c_inner (inner_c[k]),
      .g_grp   (grp_g_unused[k]),
      .p_grp   (grp_p_unused[k])
    );
    assign grp_c[k+1] = gg_p1_q[k] | (gp_p1_q[k] & grp_c[k]);
  end

  always_comb begin
    logic [WIDTH:0]   c_all;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] less;
    logic [WIDTH-1:0] res;
    logic             ovf;
    c_all = '0;
    for (int k = 0; k < NGRP; k++) begin
      c_all[GROUP*k]         = grp_c[k];
      c_all[GROUP*k+1 +: 3]  = inner_c[k];
    end
    c_all[WIDTH] = grp_c[NGRP];

    sum  = a_p1_q ^ bx_p1_q ^ c_all[WIDTH-1:0];
    ovf  = c_all[WIDTH] ^ c_all[WIDTH-1];
    // Sign of the true difference: MSB of sum corrected by overflow.
    less = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};

    case (sel_e'(op_p1_q[1:0]))
      SEL_AND: res = g_p1_q;
      SEL_OR:  res = p_p1_q;
      SEL_SUM: res = sum;
      default: res = less;
    endcase

    vld_p2_d    = s1_adv ? vld_p1_q : vld_p2_q;
    result_p2_d = result_p2_q;
    zero_p2_d   = zero_p2_q;
    ovf_p2_d    = ovf_p2_q;
    cout_p2_d   = cout_p2_q;
    if (s1_adv && vld_p1_q) begin
      result_p2_d = res;
      zero_p2_d   = (res == '0);
      ovf_p2_d    = ovf;
      cout_p2_d   = c_all[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      zero_p2_q   <= 1'b0;
      ovf_p2_q    <= 1'b0;
      cout_p2_q   <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      zero_p2_q   <= zero_p2_d;
      ovf_p2_q    <= ovf_p2_d;
      cout_p2_q   <= cout_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p1_q  <= a_p1_d;
    bx_p1_q <= bx_p1_d;
    g_p1_q  <= g_p1_d;
    p_p1_q  <= p_p1_d;
    op_p1_q <= op_p1_d;
    gg_p1_q <= gg_p1_d;
    gp_p1_q <= gp_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign result    = result_p2_q;
  assign zero      = zero_p2_q;
  assign overflow  = ovf_p2_q;
  assign cout      = cout_p2_q;

endmodule

// File: tb/tb_cla_alu_pipe.sv
module tb_cla_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_alu_pipe #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, overflow, zero, result} from plain 33-bit arithmetic.
  function automatic logic [34:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] yb;
    logic [32:0] full;
    logic [31:0] s;
    logic        v;
    logic [31:0] r;
    yb   = o[2] ? ~y : y;
    full = {1'b0, x} + {1'b0, yb} + {32'd0, o[2]};
    s    = full[31:0];
    v    = (x[31] == yb[31]) && (s[31] != x[31]);
    case (o[1:0])
      2'b00:   r = x & yb;
      2'b01:   r = x | yb;
      2'b10:   r = s;
      default: r = {31'd0, s[31] ^ v};
    endcase
    return {full[32], v, (r == 32'd0), r};
  endfunction

  task automatic one_beat(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic eo, input logic ec);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " out_valid@1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, " out_valid@2"}, out_valid, 1'b1);
    check({tag, " result"}, result, er);
    check({tag, " zero"}, zero, ez);
    check({tag, " overflow"}, overflow, eo);
    check({tag, " cout"}, cout, ec);
    @(posedge clk); #1;
    check({tag, " drained"}, out_valid, 1'b0);
  endtask

  logic [31:0] sa [10];
  logic [31:0] sb [10];
  logic [2:0]  sop [10];
  logic [34:0] sexp [10];

  initial begin
    int sent;
    int recv;
    int cyc;
    int extra;
    logic stall_prev;
    logic [31:0] held;
    logic fire_in;
    logic fire_out;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = OP_AND; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset result", result, 32'd0);
    check("reset zero", zero, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset cout", cout, 1'b0);
    reset = 1'b0;

    one_beat("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    one_beat("sub eq", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
    one_beat("slt neg", OP_SLT, 32'h8000_0000, 32'h1, 32'd1, 1'b0, 1'b1, 1'b1);
    one_beat("slt ovfc", OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0);
    one_beat("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1);
    one_beat("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b1);
    one_beat("andn", 3'b100, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 1'b1);

    // Streaming with out_ready toggling every cycle.
    for (int i = 0; i < 10; i++) begin
      sa[i]   = $urandom;
      sb[i]   = $urandom;
      sop[i]  = 3'($urandom_range(0, 7));
      sexp[i] = model(sop[i], sa[i], sb[i]);
    end
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (recv < 10 && cyc < 100) begin
      in_valid = (sent < 10);
      if (sent < 10) begin
        a = sa[sent]; b = sb[sent]; op = sop[sent];
      end
      out_ready = cyc[0];
      #4;
      if (out_valid && stall_prev) check("stream stall hold", result, held);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        check("stream result", result, sexp[recv][31:0]);
        check("stream zero", zero, sexp[recv][32]);
        check("stream overflow", overflow, sexp[recv][33]);
        check("stream cout", cout, sexp[recv][34]);
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      held = result;
      @(posedge clk); #1;
      if (fire_in) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream beats received", recv, 10);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("stream no duplicate", extra, 0);

    // Fill both stages, then reset with a simultaneous handshake offered.
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check("full out_valid", out_valid, 1'b1);
    check("full in_ready", in_ready, 1'b0);
    reset = 1'b1; out_ready = 1'b1; a = 32'd7;
    @(posedge clk); #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset in_ready", in_ready, 1'b1);
    check("midreset result", result, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("no stale beat", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
